// File: rtl/nasti_pkg.sv
// Shared definitions for the NASTI write sink and its beat packer.
//
// Contents:
//   resp_e          - B channel response codes (OKAY, SLVERR)
//   burst_e         - AW burst encodings (FIXED, INCR, WRAP)
//   state_e         - write sink transaction states
//   laneWidth()     - width of a beat-lane index for a given beats-per-word,
//                     never narrower than one bit so a single-lane word still
//                     gets a legal vector
package nasti_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_MEM,
    ST_RESP
  } state_e;

  function automatic int laneWidth(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/nasti_write_beat_packer.sv
// Collects narrow NASTI W beats into one memory-side word.
//
// Each accepted beat lands in lane (lane0 + beat offset); its strobes are
// OR-ed into that lane's byte enables so unwritten lanes keep strobe 0.
// The assembled word and byte enables are presented combinationally.
//
// Ports:
//   clk_i, rstn_i   - clock, asynchronous active-low reset
//   clear_i         - start of a new burst: drop all collected strobes
//   wr_en_i         - write the current beat into its lane
//   lane0_i         - lane of the first beat of the burst
//   laneOffset_i    - beat index within the burst (low bits of the count)
//   data_i, strb_i  - beat data and byte strobes
//   word_data_o     - assembled word
//   word_strb_o     - assembled byte enables
module nasti_write_beat_packer
  import nasti_pkg::*;
#(
  parameter int NASTI_DATA_WIDTH = 8,
  parameter int WORD_WIDTH       = 32,
  localparam int BEATS           = WORD_WIDTH / NASTI_DATA_WIDTH,
  localparam int LANE_W          = laneWidth(BEATS),
  localparam int STRB_W          = NASTI_DATA_WIDTH / 8
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        clear_i,
  input  logic                        wr_en_i,
  input  logic [LANE_W-1:0]           lane0_i,
  input  logic [LANE_W-1:0]           laneOffset_i,
  input  logic [NASTI_DATA_WIDTH-1:0] data_i,
  input  logic [STRB_W-1:0]           strb_i,
  output logic [WORD_WIDTH-1:0]       word_data_o,
  output logic [WORD_WIDTH/8-1:0]     word_strb_o
);

  logic [BEATS-1:0][NASTI_DATA_WIDTH-1:0] data_q;
  logic [BEATS-1:0][STRB_W-1:0]           strb_q;
  logic [LANE_W-1:0]                      lane;

  // The target lane wraps naturally in LANE_W bits; the top only allows
  // bursts whose lanes all fit inside one word, so no wrap ever happens
  // on a beat that is actually written.
  assign lane = lane0_i + laneOffset_i;

  // Lane buffer: strobes are cleared at the start of each burst so stale
  // byte enables from an earlier transaction can never leak into memory.
  // Data of an unstrobed lane is don't-care and is left alone.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q <= '0;
      strb_q <= '0;
    end else if (clear_i) begin
      strb_q <= '0;
    end else if (wr_en_i) begin
      for (int l = 0; l < BEATS; l++) begin
        if (lane == LANE_W'(l)) begin
          data_q[l] <= data_i;
          strb_q[l] <= strb_q[l] | strb_i;
        end
      end
    end
  end

  assign word_data_o = data_q;
  assign word_strb_o = strb_q;

endmodule

// File: rtl/nasti_word_write_sink.sv
// NASTI write-channel consumer that turns one narrow INCR burst into one
// word-wide write on a req/gnt memory port, then answers on B.
//
// One transaction is in flight at a time: AW is only accepted in IDLE, so
// W beats can never run ahead of their address. Illegal bursts (wrong burst
// type or size, misaligned, or spilling past the word) are drained and
// answered with SLVERR without a memory access. A burst with no strobes set
// is answered OKAY, also without a memory access.
//
// Ports:
//   clk_i, rstn_i              - clock, asynchronous active-low reset
//   nasti_aw_*_i / _o          - write address channel (id/addr/len/size/burst/user)
//   nasti_w_*_i / _o           - write data channel (data/strb/last/user)
//   nasti_b_*_o / _i           - write response channel (id/resp/user)
//   mem_req_o                  - word write request, held until granted
//   mem_addr_o                 - word-aligned address
//   mem_wdata_o, mem_wstrb_o   - assembled word and byte enables
//   mem_gnt_i                  - request accepted this cycle
//   mem_err_i                  - sampled with mem_gnt_i, 1 = write failed
module nasti_word_write_sink
  import nasti_pkg::*;
#(
  parameter int ID_WIDTH         = 1,
  parameter int ADDR_WIDTH       = 8,
  parameter int NASTI_DATA_WIDTH = 8,
  parameter int WORD_WIDTH       = 32,
  parameter int USER_WIDTH       = 1
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,

  input  logic [ID_WIDTH-1:0]           nasti_aw_id_i,
  input  logic [ADDR_WIDTH-1:0]         nasti_aw_addr_i,
  input  logic [7:0]                    nasti_aw_len_i,
  input  logic [2:0]                    nasti_aw_size_i,
  input  logic [1:0]                    nasti_aw_burst_i,
  input  logic [USER_WIDTH-1:0]         nasti_aw_user_i,
  input  logic                          nasti_aw_valid_i,
  output logic                          nasti_aw_ready_o,

  input  logic [NASTI_DATA_WIDTH-1:0]   nasti_w_data_i,
  input  logic [NASTI_DATA_WIDTH/8-1:0] nasti_w_strb_i,
  input  logic                          nasti_w_last_i,
  input  logic [USER_WIDTH-1:0]         nasti_w_user_i,
  input  logic                          nasti_w_valid_i,
  output logic                          nasti_w_ready_o,

  output logic [ID_WIDTH-1:0]           nasti_b_id_o,
  output logic [1:0]                    nasti_b_resp_o,
  output logic [USER_WIDTH-1:0]         nasti_b_user_o,
  output logic                          nasti_b_valid_o,
  input  logic                          nasti_b_ready_i,

  output logic                          mem_req_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [WORD_WIDTH-1:0]         mem_wdata_o,
  output logic [WORD_WIDTH/8-1:0]       mem_wstrb_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_err_i
);

  localparam int BEATS    = WORD_WIDTH / NASTI_DATA_WIDTH;
  localparam int BSZ      = $clog2(NASTI_DATA_WIDTH / 8);
  localparam int WORD_LSB = $clog2(WORD_WIDTH / 8);
  localparam int LANE_W   = laneWidth(BEATS);

  localparam logic [ADDR_WIDTH-1:0] SUB_MASK  = ADDR_WIDTH'((1 << BSZ) - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ADDR_WIDTH'((1 << WORD_LSB) - 1);

  state_e                  state_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [USER_WIDTH-1:0]   user_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LANE_W-1:0]       lane0_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic                    err_q;
  resp_e                   resp_q;
  logic                    awReady_q;
  logic                    wReady_q;
  logic                    bValid_q;
  logic                    memReq_q;

  logic                    awFire;
  logic [LANE_W-1:0]       awLane0;
  logic [9:0]              awSpan;
  logic                    awErr;
  logic                    beatFire;
  logic                    beatOverrun;
  logic                    beatWrite;
  logic                    err_d;
  logic [7:0]              cnt_d;
  logic                    anyStrb_d;
  logic [WORD_WIDTH-1:0]   wordData;
  logic [WORD_WIDTH/8-1:0] wordStrb;

  // The W user field has no meaning for a word write; it is accepted and
  // dropped.
  logic unused_wUser;
  assign unused_wUser = ^nasti_w_user_i;

  // AW decode: lane of the first beat and legality of the whole burst.
  // The span check uses a wide sum so len=255 cannot wrap into a small value.
  always_comb begin
    awLane0 = '0;
    if (BEATS > 1) awLane0 = LANE_W'(nasti_aw_addr_i >> BSZ);
    awSpan = 10'(awLane0) + 10'(nasti_aw_len_i) + 10'd1;
    awErr  = (nasti_aw_burst_i != BURST_INCR)
           | (nasti_aw_size_i != 3'(BSZ))
           | (awSpan > 10'(BEATS))
           | ((nasti_aw_addr_i & SUB_MASK) != '0);
  end

  assign awFire = awReady_q & nasti_aw_valid_i;

  // W beat decode: a beat beyond len, or a last beat at the wrong count,
  // poisons the transaction. Once poisoned, nothing more is written but
  // beats keep being drained until w_last.
  always_comb begin
    beatFire    = wReady_q & nasti_w_valid_i;
    beatOverrun = cnt_q > len_q;
    beatWrite   = beatFire & ~err_q & ~beatOverrun;
    err_d       = err_q | (beatFire & (beatOverrun |
                                       (nasti_w_last_i & (cnt_q != len_q))));
    cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    anyStrb_d   = (|wordStrb) | (beatWrite & (|nasti_w_strb_i));
  end

  nasti_write_beat_packer #(
    .NASTI_DATA_WIDTH (NASTI_DATA_WIDTH),
    .WORD_WIDTH       (WORD_WIDTH)
  ) u_packer (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clear_i      (awFire),
    .wr_en_i      (beatWrite),
    .lane0_i      (lane0_q),
    .laneOffset_i (cnt_q[LANE_W-1:0]),
    .data_i       (nasti_w_data_i),
    .strb_i       (nasti_w_strb_i),
    .word_data_o  (wordData),
    .word_strb_o  (wordStrb)
  );

  // Transaction FSM with registered handshake outputs. Each ready/valid/req
  // flag is set on the edge that enters its state and cleared on the edge
  // that leaves it, so every output is a flop and stays stable while its
  // handshake is pending.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      user_q    <= '0;
      addr_q    <= '0;
      lane0_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      resp_q    <= RESP_OKAY;
      awReady_q <= 1'b1;
      wReady_q  <= 1'b0;
      bValid_q  <= 1'b0;
      memReq_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (awFire) begin
            id_q      <= nasti_aw_id_i;
            user_q    <= nasti_aw_user_i;
            addr_q    <= nasti_aw_addr_i & ~WORD_MASK;
            lane0_q   <= awLane0;
            len_q     <= nasti_aw_len_i;
            cnt_q     <= '0;
            err_q     <= awErr;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b1;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beatFire) begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (nasti_w_last_i) begin
              wReady_q <= 1'b0;
              if (err_d) begin
                resp_q   <= RESP_SLVERR;
                bValid_q <= 1'b1;
                state_q  <= ST_RESP;
              end else if (!anyStrb_d) begin
                resp_q   <= RESP_OKAY;
                bValid_q <= 1'b1;
                state_q  <= ST_RESP;
              end else begin
                memReq_q <= 1'b1;
                state_q  <= ST_MEM;
              end
            end
          end
        end
        ST_MEM: begin
          if (mem_gnt_i) begin
            memReq_q <= 1'b0;
            resp_q   <= mem_err_i ? RESP_SLVERR : RESP_OKAY;
            bValid_q <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (nasti_b_ready_i) begin
            bValid_q  <= 1'b0;
            awReady_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign nasti_aw_ready_o = awReady_q;
  assign nasti_w_ready_o  = wReady_q;
  assign nasti_b_valid_o  = bValid_q;
  assign nasti_b_id_o     = id_q;
  assign nasti_b_user_o   = user_q;
  assign nasti_b_resp_o   = resp_q;
  assign mem_req_o        = memReq_q;
  assign mem_addr_o       = addr_q;
  assign mem_wdata_o      = wordData;
  assign mem_wstrb_o      = wordStrb;

endmodule

// File: tb/tb_nasti_word_write_sink.sv
// Directed bench for nasti_word_write_sink in the 8-bit beat / 32-bit word
// configuration. Inputs change 1ns after the rising edge; outputs are
// sampled on the falling edge.
module tb_nasti_word_write_sink;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic [0:0]  awId = '0;
  logic [7:0]  awAddr = '0;
  logic [7:0]  awLen = '0;
  logic [2:0]  awSize = '0;
  logic [1:0]  awBurst = '0;
  logic [0:0]  awUser = '0;
  logic        awValid = 1'b0;
  logic        awReady;

  logic [7:0]  wData = '0;
  logic [0:0]  wStrb = '0;
  logic        wLast = 1'b0;
  logic [0:0]  wUser = '0;
  logic        wValid = 1'b0;
  logic        wReady;

  logic [0:0]  bId;
  logic [1:0]  bResp;
  logic [0:0]  bUser;
  logic        bValid;
  logic        bReady = 1'b0;

  logic        memReq;
  logic [7:0]  memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memWstrb;
  logic        memGnt = 1'b0;
  logic        memErr = 1'b0;

  int totalChecks = 0;
  int badChecks = 0;
  int memReqCount = 0;
  int bValidCount = 0;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;

  nasti_word_write_sink #(
    .ID_WIDTH         (1),
    .ADDR_WIDTH       (8),
    .NASTI_DATA_WIDTH (8),
    .WORD_WIDTH       (32),
    .USER_WIDTH       (1)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .nasti_aw_id_i    (awId),
    .nasti_aw_addr_i  (awAddr),
    .nasti_aw_len_i   (awLen),
    .nasti_aw_size_i  (awSize),
    .nasti_aw_burst_i (awBurst),
    .nasti_aw_user_i  (awUser),
    .nasti_aw_valid_i (awValid),
    .nasti_aw_ready_o (awReady),
    .nasti_w_data_i   (wData),
    .nasti_w_strb_i   (wStrb),
    .nasti_w_last_i   (wLast),
    .nasti_w_user_i   (wUser),
    .nasti_w_valid_i  (wValid),
    .nasti_w_ready_o  (wReady),
    .nasti_b_id_o     (bId),
    .nasti_b_resp_o   (bResp),
    .nasti_b_user_o   (bUser),
    .nasti_b_valid_o  (bValid),
    .nasti_b_ready_i  (bReady),
    .mem_req_o        (memReq),
    .mem_addr_o       (memAddr),
    .mem_wdata_o      (memWdata),
    .mem_wstrb_o      (memWstrb),
    .mem_gnt_i        (memGnt),
    .mem_err_i        (memErr)
  );

  // Free-running 100MHz clock.
  always #5 clk = ~clk;

  // Background monitors: count cycles with a memory request or a B valid,
  // so tests that must not touch memory or must not respond can check it.
  always @(negedge clk) begin
    if (memReq) memReqCount++;
    if (bValid) bValidCount++;
  end

  // Hard stop in case some handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: every check counts here and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one AW request and wait (bounded) for its handshake.
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [0:0] id,
                               input logic [0:0] user, input string tag);
    bit done = 0;
    awAddr  = addr;
    awLen   = len;
    awSize  = 3'd0;
    awBurst = burst;
    awId    = id;
    awUser  = user;
    awValid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (awReady) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    awValid = 1'b0;
    if (!done) checkOutput({tag, "AwTimeout"}, 64'h0, 64'h1);
  endtask

  // Present one W beat and wait (bounded) for its handshake.
  task automatic driveBeat(input logic [7:0] data, input logic [0:0] strb,
                           input logic last, input string tag);
    bit done = 0;
    wData  = data;
    wStrb  = strb;
    wLast  = last;
    wValid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (wReady) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    wValid = 1'b0;
    wLast  = 1'b0;
    if (!done) checkOutput({tag, "WTimeout"}, 64'h0, 64'h1);
  endtask

  // Wait for mem_req, check the word, hold off the grant for 'delay' cycles
  // while checking that the request stays put, then grant with 'err'.
  task automatic serviceMem(input int delay, input logic err,
                            input logic [7:0] expAddr, input logic [31:0] expData,
                            input logic [31:0] dataMask, input logic [3:0] expStrb,
                            input string tag);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (memReq) found = 1;
    end
    if (!found) begin
      checkOutput({tag, "MemReqTimeout"}, 64'h0, 64'h1);
    end else begin
      checkOutput({tag, "MemAddr"}, 64'(memAddr), 64'(expAddr));
      checkOutput({tag, "MemWdata"}, 64'(memWdata & dataMask), 64'(expData));
      checkOutput({tag, "MemWstrb"}, 64'(memWstrb), 64'(expStrb));
      for (int d = 0; d < delay; d++) begin
        @(negedge clk);
        checkOutput({tag, "MemReqHeld"}, 64'(memReq), 64'h1);
        checkOutput({tag, "MemWdataHeld"}, 64'(memWdata & dataMask), 64'(expData));
        checkOutput({tag, "MemWstrbHeld"}, 64'(memWstrb), 64'(expStrb));
        checkOutput({tag, "AwReadyLowInMem"}, 64'(awReady), 64'h0);
      end
      memGnt = 1'b1;
      memErr = err;
      @(posedge clk);
      #1;
      memGnt = 1'b0;
      memErr = 1'b0;
    end
  endtask

  // Wait for B, check it, keep b_ready low for 'readyDelay' cycles while
  // checking that B is held, then complete the handshake and check that
  // AW is open again.
  task automatic collectResp(input int readyDelay, input logic [1:0] expResp,
                             input logic [0:0] expId, input logic [0:0] expUser,
                             input string tag);
    bit found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bValid) found = 1;
    end
    if (!found) begin
      checkOutput({tag, "BTimeout"}, 64'h0, 64'h1);
    end else begin
      checkOutput({tag, "BResp"}, 64'(bResp), 64'(expResp));
      checkOutput({tag, "BId"}, 64'(bId), 64'(expId));
      checkOutput({tag, "BUser"}, 64'(bUser), 64'(expUser));
      for (int d = 0; d < readyDelay; d++) begin
        @(negedge clk);
        checkOutput({tag, "BValidHeld"}, 64'(bValid), 64'h1);
        checkOutput({tag, "BRespHeld"}, 64'(bResp), 64'(expResp));
        checkOutput({tag, "AwReadyLowInResp"}, 64'(awReady), 64'h0);
      end
      bReady = 1'b1;
      @(posedge clk);
      #1;
      bReady = 1'b0;
      checkOutput({tag, "AwReadyAfterB"}, 64'(awReady), 64'h1);
      checkOutput({tag, "BValidAfterB"}, 64'(bValid), 64'h0);
    end
  endtask

  initial begin
    $display("[TB] starting nasti_word_write_sink bench");

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstAwReady", 64'(awReady), 64'h1);
    checkOutput("rstWReady", 64'(wReady), 64'h0);
    checkOutput("rstBValid", 64'(bValid), 64'h0);
    checkOutput("rstMemReq", 64'(memReq), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Full 4-beat word at 0x10, immediate grant and ready; latency checked.
    applyStimulus(8'h10, 8'd3, INCR, 1'b1, 1'b0, "t1");
    checkOutput("t1WReadyAfterAw", 64'(wReady), 64'h1);
    checkOutput("t1AwReadyAfterAw", 64'(awReady), 64'h0);
    driveBeat(8'h11, 1'b1, 1'b0, "t1");
    driveBeat(8'h22, 1'b1, 1'b0, "t1");
    driveBeat(8'h33, 1'b1, 1'b0, "t1");
    driveBeat(8'h44, 1'b1, 1'b1, "t1");
    checkOutput("t1MemReqLatency", 64'(memReq), 64'h1);
    serviceMem(0, 1'b0, 8'h10, 32'h4433_2211, 32'hFFFF_FFFF, 4'hF, "t1");
    collectResp(0, OKAY, 1'b1, 1'b0, "t1");

    // Two beats starting in lane 2.
    applyStimulus(8'h12, 8'd1, INCR, 1'b0, 1'b1, "t2");
    driveBeat(8'hAA, 1'b1, 1'b0, "t2");
    driveBeat(8'hBB, 1'b1, 1'b1, "t2");
    serviceMem(0, 1'b0, 8'h10, 32'hBBAA_0000, 32'hFFFF_0000, 4'hC, "t2");
    collectResp(0, OKAY, 1'b0, 1'b1, "t2");

    // FIXED burst: all beats drained, no memory access, SLVERR.
    memReqCount = 0;
    applyStimulus(8'h20, 8'd3, FIXED, 1'b1, 1'b1, "t3");
    driveBeat(8'h01, 1'b1, 1'b0, "t3");
    driveBeat(8'h02, 1'b1, 1'b0, "t3");
    driveBeat(8'h03, 1'b1, 1'b0, "t3");
    driveBeat(8'h04, 1'b1, 1'b1, "t3");
    collectResp(0, SLVERR, 1'b1, 1'b1, "t3");
    checkOutput("t3NoMemReq", 64'(memReqCount), 64'h0);

    // Early last on the second beat of a len 3 burst.
    memReqCount = 0;
    applyStimulus(8'h10, 8'd3, INCR, 1'b0, 1'b0, "t4");
    driveBeat(8'h55, 1'b1, 1'b0, "t4");
    driveBeat(8'h66, 1'b1, 1'b1, "t4");
    collectResp(0, SLVERR, 1'b0, 1'b0, "t4");
    checkOutput("t4NoMemReq", 64'(memReqCount), 64'h0);

    // Delayed grant with error, then slow B ready.
    applyStimulus(8'h04, 8'd3, INCR, 1'b1, 1'b1, "t5");
    driveBeat(8'h01, 1'b1, 1'b0, "t5");
    driveBeat(8'h02, 1'b1, 1'b0, "t5");
    driveBeat(8'h03, 1'b1, 1'b0, "t5");
    driveBeat(8'h04, 1'b1, 1'b1, "t5");
    serviceMem(4, 1'b1, 8'h04, 32'h0403_0201, 32'hFFFF_FFFF, 4'hF, "t5");
    collectResp(5, SLVERR, 1'b1, 1'b1, "t5");

    // Reset in the middle of a burst aborts it without a response.
    applyStimulus(8'h20, 8'd3, INCR, 1'b1, 1'b0, "t6");
    driveBeat(8'h77, 1'b1, 1'b0, "t6");
    driveBeat(8'h88, 1'b1, 1'b0, "t6");
    rstn = 1'b0;
    #1;
    checkOutput("t6RstAwReady", 64'(awReady), 64'h1);
    checkOutput("t6RstWReady", 64'(wReady), 64'h0);
    checkOutput("t6RstBValid", 64'(bValid), 64'h0);
    checkOutput("t6RstMemReq", 64'(memReq), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    bValidCount = 0;
    memReqCount = 0;
    repeat (5) @(negedge clk);
    checkOutput("t6NoBAfterReset", 64'(bValidCount), 64'h0);
    checkOutput("t6NoMemAfterReset", 64'(memReqCount), 64'h0);
    @(posedge clk);
    #1;
    applyStimulus(8'h20, 8'd3, INCR, 1'b0, 1'b1, "t7");
    driveBeat(8'h01, 1'b1, 1'b0, "t7");
    driveBeat(8'h02, 1'b1, 1'b0, "t7");
    driveBeat(8'h03, 1'b1, 1'b0, "t7");
    driveBeat(8'h04, 1'b1, 1'b1, "t7");
    serviceMem(0, 1'b0, 8'h20, 32'h0403_0201, 32'hFFFF_FFFF, 4'hF, "t7");
    collectResp(0, OKAY, 1'b0, 1'b1, "t7");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/nasti_word_write_sink.md
Name: nasti_word_write_sink

Overview:
- Downstream NASTI write-channel consumer. It sits behind the lite-to-NASTI write converter and accepts its narrow INCR bursts.
- Reassembles each burst into one WORD_WIDTH-wide write on a simple req/gnt memory/register port, then returns a B response.
- Handles one transaction at a time; rejects illegal bursts with SLVERR without touching memory.

Parameters:
- ID_WIDTH, 1, NASTI id width
- ADDR_WIDTH, 8, address width
- NASTI_DATA_WIDTH, 8, NASTI W beat width (8..WORD_WIDTH, power of 2)
- WORD_WIDTH, 32, memory-side word width (32 or 64)
- USER_WIDTH, 1, user field width (>0)

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- nasti_aw_id/addr/len/size/burst/user  in  ID_WIDTH/ADDR_WIDTH/8/3/2/USER_WIDTH  write address; lock/cache/prot/qos/region are not consumed
- nasti_aw_valid  in  1; nasti_aw_ready  out  1
- nasti_w_data/strb/last/user  in  NASTI_DATA_WIDTH/NASTI_DATA_WIDTH/8/1/USER_WIDTH  write beat
- nasti_w_valid  in  1; nasti_w_ready  out  1
- nasti_b_id/resp/user  out  ID_WIDTH/2/USER_WIDTH  response
- nasti_b_valid  out  1; nasti_b_ready  in  1
- mem_req  out  1  word write request, held until granted
- mem_addr  out  ADDR_WIDTH  word-aligned address
- mem_wdata  out  WORD_WIDTH  assembled word
- mem_wstrb  out  WORD_WIDTH/8  assembled byte enables
- mem_gnt  in  1  request accepted this cycle
- mem_err  in  1  sampled with mem_gnt; 1 means write failed

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rstn).
- Reset: state IDLE. aw_ready=1 (IDLE decode); w_ready=0, b_valid=0, mem_req=0. Beat counter, error flag and strobe buffer cleared.
- Constants:
  - BEATS = WORD_WIDTH/NASTI_DATA_WIDTH
  - BSZ = log2(NASTI_DATA_WIDTH/8)
  - lane0 = addr[log2(WORD_WIDTH/8)-1:BSZ]
- State IDLE: aw_ready=1, all else 0. On AW handshake:
  - latch id, user, and word-aligned addr (low log2(WORD_WIDTH/8) bits zeroed); latch lane0; clear strb buffer and beat count.
  - err = (burst!=INCR) | (size!=BSZ) | (lane0+len+1 > BEATS) | (addr[BSZ-1:0]!=0).
  - next state DATA.
- State DATA: w_ready=1.
  - Each W handshake with !err: write data into lane (lane0+cnt) of the word buffer; OR strb into that lane's strobe bits. cnt increments, saturating at 255.
  - err set if last arrives with cnt!=len, or a beat arrives when cnt>len (no write for that beat).
  - All beats are drained until w_last regardless of err.
  - On last handshake: err→RESP(SLVERR); all strobes 0→RESP(OKAY, no mem access); else→MEM.
- State MEM: mem_req=1, outputs stable until mem_gnt. On gnt: resp=mem_err?SLVERR:OKAY; next state RESP.
- State RESP: b_valid=1, b_id/b_user = latched values, b_resp per above. Held stable until b_ready, then IDLE.
- aw_ready=0 outside IDLE, so W can never be accepted before its AW.
- Latency with gnt/ready immediate: AW at cycle 0, N beats at cycles 1..N, mem_req at N+1, b_valid at N+2, next aw_ready at N+3.
- Beat-lane assembly is bytewise: unwritten lanes carry strb 0 and their data is don't-care.
- Reset mid-transaction aborts it immediately: no B is issued and no partial mem_req remains.

Decomposition:
- Shared package nasti_pkg:
  - resp codes OKAY=2'b00, SLVERR=2'b10
  - burst encodings FIXED/INCR/WRAP
  - state enum {IDLE, DATA, MEM, RESP}
- One natural sub-module, nasti_write_beat_packer: lane index, data/strb buffer and clear/write, combinational word output.
- FSM and channel handshakes stay in the top module.

Test Plan:
- 8/32 config, AW addr 0x10 len 3 size 0 INCR; beats 0x11,0x22,0x33,0x44 strb 1 -> mem_addr 0x10, wdata 0x44332211, wstrb 0xF, B OKAY, id echoed.
- AW addr 0x12 len 1; beats 0xAA,0xBB -> wdata[31:16]=0xBBAA, wstrb 0xC.
- AW burst FIXED len 3; 4 beats -> all beats accepted, no mem_req, B SLVERR.
- Last asserted on beat 2 of a len 3 burst -> B SLVERR, no mem_req; next AW accepted.
- mem_gnt delayed 4 cycles with mem_err=1; b_ready low 5 cycles -> mem_req and outputs stable; b_valid held with resp SLVERR; aw_ready 0 until the B handshake.
- rstn pulsed low after 2 beats -> outputs at reset values next edge, no B issued; a fresh 4-beat burst completes OKAY.
